// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: PC register, IF/ID pipeline register, stall/redirect handling.
// Optional static backward-taken/forward-not-taken predictor enabled by macro IF_BTFN_PREDICT_EN.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0033
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_instr,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_instr,
  output logic        o_id_valid,
  output logic        o_id_pred_taken
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] seq_pc;
  logic        pred_taken;
  logic [31:0] id_pc_reg;
  logic [31:0] id_instr_reg;
  logic        id_valid_reg;
  logic        id_pred_reg;

  assign seq_pc = pc_reg + 32'd4;

`ifdef IF_BTFN_PREDICT_EN
  logic [31:0] b_imm;
  logic        is_branch;

  assign b_imm = {{20{i_imem_instr[31]}}, i_imem_instr[7], i_imem_instr[30:25],
                  i_imem_instr[11:8], 1'b0};
  assign is_branch  = (i_imem_instr[6:0] == 7'b1100011);
  // Sign bit of the B-immediate marks a backward branch.
  assign pred_taken = is_branch & i_imem_instr[31];
  assign pc_next    = pred_taken ? ((pc_reg + b_imm) & ALIGN_MASK) : seq_pc;
`else
  assign pred_taken = 1'b0;
  assign pc_next    = seq_pc;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_reg       <= RESET_PC & ALIGN_MASK;
      id_pc_reg    <= RESET_PC;
      id_instr_reg <= NOP_INSTR;
      id_valid_reg <= 1'b0;
      id_pred_reg  <= 1'b0;
    end else if (i_redirect) begin
      // Redirect wins over stall; the ID slot becomes a bubble, its pc is kept.
      pc_reg       <= i_redirect_pc & ALIGN_MASK;
      id_instr_reg <= NOP_INSTR;
      id_valid_reg <= 1'b0;
      id_pred_reg  <= 1'b0;
    end else if (!i_stall) begin
      pc_reg       <= pc_next;
      id_pc_reg    <= pc_reg;
      id_instr_reg <= i_imem_instr;
      id_valid_reg <= 1'b1;
      id_pred_reg  <= pred_taken;
    end
  end

  assign o_imem_addr     = pc_reg;
  assign o_id_pc         = id_pc_reg;
  assign o_id_instr      = id_instr_reg;
  assign o_id_valid      = id_valid_reg;
  assign o_id_pred_taken = id_pred_reg;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Table-driven bench for if_fetch_ctrl with a small instruction-memory model.
// Expectations adapt to whether IF_BTFN_PREDICT_EN is defined.
module tb_if_fetch_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_instr;
  logic        i_stall = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = 32'h0;
  logic [31:0] o_id_pc;
  logic [31:0] o_id_instr;
  logic        o_id_valid;
  logic        o_id_pred_taken;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [31:0] BEQ_BACK = 32'hFE00_86E3;  // beq x1,x0,-20
  localparam logic [31:0] BEQ_FWD  = 32'h0000_8463;  // beq x1,x0,+8
  localparam logic [31:0] NOP      = 32'h0000_0033;

  if_fetch_ctrl dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .o_imem_addr    (o_imem_addr),
    .i_imem_instr   (i_imem_instr),
    .i_stall        (i_stall),
    .i_redirect     (i_redirect),
    .i_redirect_pc  (i_redirect_pc),
    .o_id_pc        (o_id_pc),
    .o_id_instr     (o_id_instr),
    .o_id_valid     (o_id_valid),
    .o_id_pred_taken(o_id_pred_taken)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    if (a == 32'd0)  return 32'h0010_8093;
    if (a == 32'd36) return BEQ_BACK;
    if (a == 32'd64) return BEQ_FWD;
    return {a[23:0], 8'h13};
  endfunction

  initial i_imem_instr = mem_at(32'd0);
  always @(negedge i_clk) i_imem_instr = mem_at(o_imem_addr);

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] exp_addr;
    logic [31:0] exp_id_pc;
    logic [31:0] exp_id_instr;
    logic        exp_valid;
    logic        exp_pred;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic st, input logic rd,
                              input logic [31:0] rpc, input logic [31:0] addr,
                              input logic [31:0] idpc, input logic [31:0] ins,
                              input logic v, input logic p);
    vec_t t;
    t.rst = rst; t.stall = st; t.redirect = rd; t.redirect_pc = rpc;
    t.exp_addr = addr; t.exp_id_pc = idpc; t.exp_id_instr = ins;
    t.exp_valid = v; t.exp_pred = p;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] addr, input logic [31:0] idpc,
                       input logic [31:0] ins, input logic v, input logic p);
    tests_run++;
    if (o_imem_addr !== addr || o_id_pc !== idpc || o_id_instr !== ins ||
        o_id_valid !== v || o_id_pred_taken !== p) begin
      tests_failed++;
      $display("FAIL %s: got addr=%h id_pc=%h instr=%h valid=%b pred=%b, want addr=%h id_pc=%h instr=%h valid=%b pred=%b",
               name, o_imem_addr, o_id_pc, o_id_instr, o_id_valid, o_id_pred_taken,
               addr, idpc, ins, v, p);
    end else begin
      $display("[TB] %s: addr=%h id_pc=%h instr=%h valid=%b pred=%b ok",
               name, o_imem_addr, o_id_pc, o_id_instr, o_id_valid, o_id_pred_taken);
    end
  endtask

  task automatic apply(input vec_t t);
    i_rst = t.rst; i_stall = t.stall; i_redirect = t.redirect; i_redirect_pc = t.redirect_pc;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  logic [31:0] after_br;
  logic        bt;

  initial begin
`ifdef IF_BTFN_PREDICT_EN
    bt = 1'b1; after_br = 32'd16;
`else
    bt = 1'b0; after_br = 32'd40;
`endif
    // Free run, stall at PC=12, redirect with stall, repeated redirect
    vecs.push_back(mk(0, 0, 0, 0, 32'd4,  32'd0,  32'h0010_8093, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'd8,  32'd4,  mem_at(4),  1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'd12, 32'd8,  mem_at(8),  1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'd12, 32'd8,  mem_at(8),  1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'd12, 32'd8,  mem_at(8),  1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'd16, 32'd12, mem_at(12), 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'd20, 32'd16, mem_at(16), 1, 0));
    vecs.push_back(mk(0, 1, 1, 32'h27, 32'h24, 32'd16, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h27, 32'h24, 32'd16, NOP, 0, 0));
    // Backward branch at 36
    vecs.push_back(mk(0, 0, 0, 0, after_br, 32'd36, BEQ_BACK, 1, bt));
    vecs.push_back(mk(0, 0, 0, 0, after_br + 32'd4, after_br, mem_at(after_br), 1, 0));
    // Forward branch at 64 is never predicted taken
    vecs.push_back(mk(0, 0, 1, 32'h40, 32'h40, after_br, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h44, 32'h40, BEQ_FWD, 1, 0));
    // Wrap at the top of the address space
    vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h40, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'd0, 32'hFFFF_FFFC, mem_at(32'hFFFF_FFFC), 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'd4, 32'd0, 32'h0010_8093, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'd8, 32'd4, mem_at(4), 1, 0));

    // Reset for three cycles
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("reset", 32'd0, 32'd0, NOP, 0, 0);

    foreach (vecs[k]) begin
      apply(vecs[k]);
      check($sformatf("vec%0d", k), vecs[k].exp_addr, vecs[k].exp_id_pc,
            vecs[k].exp_id_instr, vecs[k].exp_valid, vecs[k].exp_pred);
    end

    // Reset mid-stream overrides a simultaneous redirect and stall
    apply(mk(1, 1, 1, 32'h100, 0, 0, 0, 0, 0));
    check("rst_over_redirect", 32'd0, 32'd0, NOP, 0, 0);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("post_rst_first", 32'd4, 32'd0, 32'h0010_8093, 1, 0);

    // Stall after a redirect keeps the bubble in place
    apply(mk(0, 0, 1, 32'h24, 0, 0, 0, 0, 0));
    check("redirect_36", 32'h24, 32'd0, NOP, 0, 0);
    apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    check("stall_bubble", 32'h24, 32'd0, NOP, 0, 0);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("branch_after_stall", after_br, 32'd36, BEQ_BACK, 1, bt);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset (word-aligned).
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0033, meaning bubble encoding (add x0,x0,x0).
REQ-003 i_clk  input  1  single clock; all state updates on posedge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 o_imem_addr  output  32  fetch address to instruction memory (current PC).
REQ-006 i_imem_instr  input  32  instruction word for o_imem_addr; memory updates it on negedge, so it is stable before the next posedge.
REQ-007 i_stall  input  1  hazard unit hold request.
REQ-008 i_redirect  input  1  EX-stage redirect (taken branch or mispredict).
REQ-009 i_redirect_pc  input  32  redirect target.
REQ-010 o_id_pc  output  32  IF/ID register: PC of captured instruction.
REQ-011 o_id_instr  output  32  IF/ID register: captured instruction.
REQ-012 o_id_valid  output  1  IF/ID register: captured instruction is real, not a bubble.
REQ-013 o_id_pred_taken  output  1  IF/ID register: fetch predicted this instruction taken (0 when predictor is compiled out).

Function
REQ-014 o_imem_addr SHALL equal the PC register combinationally, with bits [1:0] always 0.
REQ-015 Normal cycle (no stall, no redirect): IF/ID <= {PC, i_imem_instr, valid=1, pred}; PC <= next_pc; one-cycle fetch-to-ID latency.
REQ-016 next_pc SHALL be PC+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0.
REQ-017 Stall (i_stall=1, i_redirect=0): PC and all IF/ID outputs SHALL hold their values.
REQ-018 Redirect (i_redirect=1): PC <= {i_redirect_pc[31:2],2'b00}; IF/ID <= {pc unchanged, NOP_INSTR, valid=0, pred=0}.
REQ-019 Redirect SHALL take priority over stall when both are asserted in one cycle.
REQ-020 Redirect held for N consecutive cycles SHALL reload the same target N times and emit N bubbles.
REQ-021 The first posedge with i_rst=0 SHALL capture the instruction at RESET_PC with o_id_valid=1.
REQ-022 No internal state SHALL depend on i_imem_instr except the IF/ID capture and predictor decode.

Reset
REQ-023 With i_rst=1 at posedge: PC <= RESET_PC, o_id_pc <= RESET_PC, o_id_instr <= NOP_INSTR, o_id_valid <= 0, o_id_pred_taken <= 0.
REQ-024 Reset SHALL override stall and redirect; reset asserted mid-stream discards any pending redirect.

Configuration
REQ-025 Macro IF_BTFN_PREDICT_EN SHALL enable the static backward-taken/forward-not-taken predictor.
REQ-026 With the macro defined: if i_imem_instr[6:0]=7'b1100011 and B-immediate bit 12 = 1 (negative), next_pc = PC + sign-extended B-immediate, and the captured pred bit = 1; otherwise next_pc = PC+4 and pred = 0.
REQ-027 Predicted target arithmetic SHALL be 32-bit with wrap; the predictor decode SHALL NOT apply during stall, redirect or reset.
REQ-028 Without the macro: next_pc is always PC+4, o_id_pred_taken is tied to 0, and no decode logic is present.

Verification
REQ-029 Reset 3 cycles then release, memory returns 32'h0010_8093 at addr 0 -> first posedge: o_id_pc=0, o_id_instr=32'h0010_8093, o_id_valid=1; o_imem_addr=4.
REQ-030 Free-run 5 cycles -> o_imem_addr sequence 4,8,12,16,20; o_id_pc lags by one cycle.
REQ-031 i_stall=1 for 2 cycles at PC=12 -> o_imem_addr stays 12, IF/ID holds pc 8; resumes at 16.
REQ-032 i_redirect=1, i_redirect_pc=32'h0000_0027, with i_stall=1 -> PC=0x24, o_id_valid=0, o_id_instr=32'h0000_0033.
REQ-033 With IF_BTFN_PREDICT_EN: BEQ x1,x0,-20 (32'hFE00_86E3) at PC=36 -> next o_imem_addr=16, o_id_pred_taken=1; forward BEQ +8 -> PC+4, pred 0; without macro -> 40, pred 0.
REQ-034 PC forced to 32'hFFFF_FFFC via redirect, one normal cycle -> o_imem_addr=0, o_id_pc=32'hFFFF_FFFC.
